// File: rtl/decrypt_function_2_if.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_function_2_if
// Description : Valid/ready bus bundle for decrypt_function_2. Carries the
//               encrypted-word input channel (in_valid/in_ready/inEnc) and the
//               plaintext output channel (out_valid/out_ready/outDec/outTag/
//               outErr).
//               slave  : the decryptor's view (consumes inEnc, produces outDec)
//               master : the surrounding logic's view (producer + consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface decrypt_function_2_if;
  logic        in_valid;
  logic        in_ready;
  logic [77:0] inEnc;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] outDec;
  logic [5:0]  outTag;
  logic        outErr;

  modport slave (
    input  in_valid, inEnc, out_ready,
    output in_ready, out_valid, outDec, outTag, outErr
  );

  modport master (
    output in_valid, inEnc, out_ready,
    input  in_ready, out_valid, outDec, outTag, outErr
  );
endinterface
`default_nettype wire

// File: rtl/decrypt_function_2.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_function_2
// Description : Two-stage valid/ready decryptor. Rebuilds the 60-bit key
//               pattern from the 11-bit random field of the encrypted word and
//               subtracts it from the 61-bit sum to recover the plaintext.
//               Flags words whose difference underflows or exceeds 60 bits,
//               and keeps a saturating count of delivered error words.
// Ports       : Clk      - system clock, rising edge
//               Rst_n    - asynchronous active-low reset
//               bus      - slave modport: inEnc channel in, outDec channel out
//               errCount - saturating count of delivered words with outErr=1
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_function_2 (
  input  wire logic       Clk,
  input  wire logic       Rst_n,
  decrypt_function_2_if.slave bus,
  output logic [15:0]     errCount
);

  localparam logic [15:0] c_ERR_MAX = 16'hFFFF;

  // Key pattern: k, k, ~k, ~k, k, k[4:0] from LSB upward.
  function automatic logic [59:0] expand_key(input logic [10:0] k);
    return {k[4:0], k, ~k, ~k, k, k};
  endfunction

  // Stage 1 registers
  logic        r_s1_valid;
  logic [60:0] r_s1_x;
  logic [59:0] r_s1_b;
  logic [5:0]  r_s1_tag;

  // Stage 2 registers (drive the outputs directly)
  logic        r_s2_valid;
  logic [59:0] r_out_dec;
  logic [5:0]  r_out_tag;
  logic        r_out_err;
  logic [15:0] r_err_count;

  logic        w_s2_adv;
  logic        w_in_ready;
  logic        w_out_hs;
  logic [61:0] w_diff;

  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  // S1 can take a word when empty or when its content moves into S2.
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_out_hs   = r_s2_valid && bus.out_ready;
  // One extra bit on each side: bit 61 is the borrow, bit 60 flags an
  // over-range difference.
  assign w_diff     = {1'b0, r_s1_x} - {2'b00, r_s1_b};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_x   <= bus.inEnc[66:6];
        r_s1_b   <= expand_key(bus.inEnc[77:67]);
        r_s1_tag <= bus.inEnc[5:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_dec  <= '0;
      r_out_tag  <= '0;
      r_out_err  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_dec <= w_diff[59:0];
        r_out_tag <= r_s1_tag;
        r_out_err <= w_diff[61] | w_diff[60];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_err_count <= '0;
    end else if (w_out_hs && r_out_err && (r_err_count != c_ERR_MAX)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.outDec    = r_out_dec;
  assign bus.outTag    = r_out_tag;
  assign bus.outErr    = r_out_err;
  assign errCount      = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_decrypt_function_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_decrypt_function_2
// Description : Self-checking bench for decrypt_function_2. Directed steps in
//               one initial block push expected results into a scoreboard
//               queue; a negedge monitor pops and compares on each output
//               handshake and checks output stability during stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decrypt_function_2;

  typedef struct packed {
    logic [59:0] dec;
    logic [5:0]  tag;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_count;
  int          checks;
  int          failures;
  int          cyc;
  int          consec;
  int          last_pop_cyc;
  int          stalls;
  int          exp_errcnt;
  exp_t        sb[$];

  decrypt_function_2_if bus_if ();

  decrypt_function_2 dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .bus      (bus_if.slave),
    .errCount (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] key_of(input logic [10:0] k);
    logic [59:0] b;
    b[10:0]  = k;
    b[21:11] = k;
    b[32:22] = ~k;
    b[43:33] = ~k;
    b[54:44] = k;
    b[59:55] = k[4:0];
    return b;
  endfunction

  // Reference encryptor: x = data + key pattern.
  function automatic logic [77:0] encrypt(input logic [59:0] data, input logic [10:0] k,
                                          input logic [5:0] t);
    logic [60:0] x;
    x = {1'b0, data} + {1'b0, key_of(k)};
    return {k, x, t};
  endfunction

  // Drive one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [77:0] w, input exp_t e);
    bit ok;
    ok = 0;
    bus_if.in_valid = 1'b1;
    bus_if.inEnc    = w;
    sb.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor plus stall-stability check.
  logic        prev_stall;
  logic [59:0] prev_dec;
  logic [5:0]  prev_tag;
  logic        prev_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus_if.out_valid), 64'd1);
        check("stall_dec", 64'(bus_if.outDec), 64'(prev_dec));
        check("stall_tag", 64'(bus_if.outTag), 64'(prev_tag));
        check("stall_err", 64'(bus_if.outErr), 64'(prev_err));
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("outDec", 64'(bus_if.outDec), 64'(e.dec));
          check("outTag", 64'(bus_if.outTag), 64'(e.tag));
          check("outErr", 64'(bus_if.outErr), 64'(e.err));
        end
        if (cyc == last_pop_cyc + 1) consec++;
        last_pop_cyc = cyc;
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_dec   = bus_if.outDec;
      prev_tag   = bus_if.outTag;
      prev_err   = bus_if.outErr;
    end
  end

  initial begin
    logic [59:0] b0;
    logic [59:0] data;
    logic [10:0] k;
    logic [5:0]  t;
    logic [59:0] neg_b0;
    logic [77:0] w_borrow;
    int          c0;
    exp_t        e;

    checks = 0; failures = 0; cyc = 0; consec = 0; last_pop_cyc = -10;
    stalls = 0; exp_errcnt = 0; prev_stall = 1'b0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.inEnc     = '0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    check("rst_outDec", 64'(bus_if.outDec), 64'd0);
    check("rst_outTag", 64'(bus_if.outTag), 64'd0);
    check("rst_outErr", 64'(bus_if.outErr), 64'd0);
    check("rst_errCount", 64'(err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero key, x equal to the key pattern, with latency check.
    b0 = key_of(11'd0);
    check("key_zero", 64'(b0), 64'h0000_0FFF_FFC0_0000);
    e = '{dec: 60'd0, tag: 6'h15, err: 1'b0};
    send({11'd0, {1'b0, b0}, 6'h15}, e);
    check("lat_edge1_valid", 64'(bus_if.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", 64'(bus_if.out_valid), 64'd1);
    check("lat_tag", 64'(bus_if.outTag), 64'h15);
    drain();

    // Borrow error: x = 0, so the difference wraps to -b.
    neg_b0 = 60'd0 - b0;
    w_borrow = {11'd0, 61'd0, 6'h2A};
    send(w_borrow, '{dec: neg_b0, tag: 6'h2A, err: 1'b1});
    exp_errcnt++;
    drain();
    check("errcnt_borrow", 64'(err_count), 64'(exp_errcnt));

    // Overflow error: x = 2^60 + b.
    send({11'd0, {1'b1, b0}, 6'h01}, '{dec: 60'd0, tag: 6'h01, err: 1'b1});
    exp_errcnt++;
    drain();
    check("errcnt_overflow", 64'(err_count), 64'(exp_errcnt));

    // Back-to-back random round trip.
    c0 = consec;
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      data = {$urandom(), $urandom()};
      k    = 11'($urandom_range(0, 2047));
      t    = 6'($urandom_range(0, 63));
      send(encrypt(data, k, t), '{dec: data, tag: t, err: 1'b0});
    end
    drain();
    check("rt_input_stalls", 64'(stalls), 64'd0);
    check("rt_output_consecutive", 64'(consec - c0 >= 999), 64'd1);
    check("errcnt_after_rt", 64'(err_count), 64'(exp_errcnt));

    // Backpressure: two words fill the pipe, the third waits.
    bus_if.out_ready = 1'b0;
    data = 60'h123_4567_89AB_CDEF;
    send(encrypt(data, 11'h5A5, 6'h11), '{dec: data, tag: 6'h11, err: 1'b0});
    data = 60'hFED_CBA9_8765_4321;
    send(encrypt(data, 11'h7FF, 6'h22), '{dec: data, tag: 6'h22, err: 1'b0});
    check("bp_in_ready_low", 64'(bus_if.in_ready), 64'd0);
    data = 60'h0F0_F0F0_F0F0_F0F0;
    bus_if.in_valid = 1'b1;
    bus_if.inEnc    = encrypt(data, 11'h001, 6'h33);
    sb.push_back('{dec: data, tag: 6'h33, err: 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("bp_third_waits", 64'(bus_if.in_ready), 64'd0);
    check("bp_sb_depth", 64'(sb.size()), 64'd3);
    bus_if.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    drain();

    // Saturation: more error words than the counter can hold.
    bus_if.in_valid = 1'b1;
    bus_if.inEnc    = w_borrow;
    for (int i = 0; i < 65540; i++) begin
      sb.push_back('{dec: neg_b0, tag: 6'h2A, err: 1'b1});
      @(posedge clk);
    end
    #1;
    bus_if.in_valid = 1'b0;
    drain();
    check("errcnt_saturated", 64'(err_count), 64'hFFFF);

    // Reset with both stages full.
    bus_if.out_ready = 1'b0;
    send(encrypt(60'h1, 11'h3, 6'h3), '{dec: 60'h1, tag: 6'h3, err: 1'b0});
    send(encrypt(60'h2, 11'h4, 6'h4), '{dec: 60'h2, tag: 6'h4, err: 1'b0});
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst_errCount", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    data = 60'hABC_DEF0_1234_5678;
    send(encrypt(data, 11'h2B3, 6'h3C), '{dec: data, tag: 6'h3C, err: 1'b0});
    drain();
    check("post_rst_errCount", 64'(err_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
